// File: rtl/tcp_toe_pkg.sv
// Shared types and constants for the TCP offload receive path:
// extractor FSM states, the connection tuple and protocol constants.
package tcp_toe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARSE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SETUP = 3'd3,
    ST_REQ   = 3'd4,
    ST_RESP  = 3'd5
  } te_state_t;

  typedef struct packed {
    logic [23:0] mac_src;
    logic [23:0] mac_dst;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] port_src;
    logic [15:0] port_dst;
  } tuple_t;

  localparam logic [15:0] ETH_IPV4    = 16'h0800;
  localparam logic [7:0]  PROTO_TCP   = 8'h06;
  localparam logic [1:0]  RQ_LOOKUP   = 2'b01;
  localparam logic [1:0]  RQ_IDLE     = 2'b00;
  localparam logic [7:0]  ERR_TIMEOUT = 8'hFF;

endpackage

// File: rtl/tcp_tuple_extractor_if.sv
// Bundle of the frame stream, searcher request/response and descriptor
// signals around the tuple extractor. The slave modport is the extractor.
// Handshakes: a word (or descriptor) transfers on a rising clock edge where
// valid and ready are both 1; valid-side data holds until that transfer.
interface tcp_tuple_extractor_if #(parameter int DROP_CNT_W = 16);
  import tcp_toe_pkg::*;

  logic [31:0]           te_in_data;
  logic                  te_in_valid;
  logic                  te_in_sop;
  logic                  te_in_eop;
  logic                  te_in_ready;
  logic [1:0]            te_rq;
  logic [23:0]           te_mac_src;
  logic [23:0]           te_mac_dst;
  logic [31:0]           te_ip_src;
  logic [31:0]           te_ip_dst;
  logic [15:0]           te_port_src;
  logic [15:0]           te_port_dst;
  logic                  te_rs_done;
  logic [7:0]            te_rs_error;
  logic [7:0]            te_rs_id;
  logic                  te_out_valid;
  logic                  te_out_ready;
  logic [7:0]            te_out_id;
  logic [7:0]            te_out_error;
  logic [DROP_CNT_W-1:0] te_drop_cnt;
  te_state_t             te_dbg_state;

  modport slave (
    input  te_in_data, te_in_valid, te_in_sop, te_in_eop,
    input  te_rs_done, te_rs_error, te_rs_id, te_out_ready,
    output te_in_ready, te_rq, te_mac_src, te_mac_dst, te_ip_src, te_ip_dst,
    output te_port_src, te_port_dst, te_out_valid, te_out_id, te_out_error,
    output te_drop_cnt, te_dbg_state
  );

  modport master (
    output te_in_data, te_in_valid, te_in_sop, te_in_eop,
    output te_rs_done, te_rs_error, te_rs_id, te_out_ready,
    input  te_in_ready, te_rq, te_mac_src, te_mac_dst, te_ip_src, te_ip_dst,
    input  te_port_src, te_port_dst, te_out_valid, te_out_id, te_out_error,
    input  te_drop_cnt, te_dbg_state
  );

endinterface

// File: rtl/tcp_hdr_capture.sv
// Word indexer and header field capture. Tracks the index of each accepted
// word, stores tuple fields as they pass, and flags header mismatches and
// the word carrying the destination port.
module tcp_hdr_capture
  import tcp_toe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic        beat_i,
  input  logic        sop_i,
  input  logic        cap_en_i,
  output tuple_t      tuple_o,
  output logic        bad_o,
  output logic        last_o
);

  logic [4:0] idx_q, idx_d, cur_idx;
  logic [3:0] ihl_q, ihl_d;
  tuple_t     tup_q, tup_d;
  logic       port_ok;

  // Index/field next-state and per-word validation flags.
  always_comb begin
    cur_idx = sop_i ? 5'd0 : idx_q;
    idx_d   = idx_q;
    ihl_d   = ihl_q;
    tup_d   = tup_q;
    bad_o   = 1'b0;
    last_o  = 1'b0;
    // Port words sit past the IP addresses; this also keeps a stale IHL
    // from an earlier frame from matching the first few words.
    port_ok = (cur_idx >= 5'd8);
    if (beat_i) idx_d = (cur_idx == 5'd31) ? 5'd31 : cur_idx + 5'd1;
    if (cap_en_i) begin
      case (cur_idx)
        5'd0: tup_d.mac_dst[23:16] = data_i[7:0];
        5'd1: tup_d.mac_dst[15:0]  = data_i[31:16];
        5'd2: tup_d.mac_src        = data_i[23:0];
        5'd3: begin
          ihl_d = data_i[11:8];
          if (data_i[31:16] != ETH_IPV4 || data_i[15:12] != 4'd4 ||
              data_i[11:8] < 4'd5) bad_o = 1'b1;
        end
        5'd5: if (data_i[7:0] != PROTO_TCP) bad_o = 1'b1;
        5'd6: tup_d.ip_src[31:16] = data_i[15:0];
        5'd7: begin
          tup_d.ip_src[15:0]  = data_i[31:16];
          tup_d.ip_dst[31:16] = data_i[15:0];
        end
        5'd8: tup_d.ip_dst[15:0] = data_i[31:16];
        default: ;
      endcase
      if (port_ok && cur_idx == 5'd3 + {1'b0, ihl_q}) tup_d.port_src = data_i[15:0];
      if (port_ok && cur_idx == 5'd4 + {1'b0, ihl_q}) begin
        tup_d.port_dst = data_i[31:16];
        last_o         = 1'b1;
      end
    end
  end

  // Index, IHL and captured tuple registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idx_q <= 5'd0;
      ihl_q <= 4'd0;
      tup_q <= '0;
    end else begin
      idx_q <= idx_d;
      ihl_q <= ihl_d;
      tup_q <= tup_d;
    end
  end

  assign tuple_o = tup_q;

endmodule

// File: rtl/tcp_tuple_extractor.sv
// Receive-side tuple extractor: parses Ethernet/IPv4/TCP frames, issues a
// lookup/insert request to the connection searcher after a two-cycle setup,
// and returns the searcher's answer as a descriptor. Bad frames are counted.
module tcp_tuple_extractor
  import tcp_toe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DROP_CNT_W     = 16
) (
  input logic                  te_clk,
  input logic                  te_rst_n,
  tcp_tuple_extractor_if.slave te
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  te_state_t             state_q, state_d;
  logic                  drop_q, drop_d;
  logic                  setup_q, setup_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [7:0]            id_q, id_d, err_q, err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [1:0]            drop_inc;
  logic                  in_ready, beat, cap_en, hdr_bad, hdr_last;
  logic [1:0]            rq;
  logic                  out_valid;
  tuple_t                tuple;

  assign in_ready = te_rst_n &&
                    (state_q == ST_IDLE || state_q == ST_PARSE || state_q == ST_DRAIN);
  assign beat     = te.te_in_valid && in_ready;

  tcp_hdr_capture u_cap (
    .clk_i    (te_clk),
    .rst_n_i  (te_rst_n),
    .data_i   (te.te_in_data),
    .beat_i   (beat),
    .sop_i    (te.te_in_sop),
    .cap_en_i (cap_en),
    .tuple_o  (tuple),
    .bad_o    (hdr_bad),
    .last_o   (hdr_last)
  );

  // FSM next state, request/descriptor outputs and drop events.
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    setup_d   = setup_q;
    tmo_d     = tmo_q;
    id_d      = id_q;
    err_d     = err_q;
    drop_inc  = 2'd0;
    cap_en    = 1'b0;
    rq        = RQ_IDLE;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat && te.te_in_sop) begin
          cap_en = 1'b1;
          drop_d = 1'b0;
          if (te.te_in_eop) drop_inc = 2'd1;  // one-word frame is truncated
          else              state_d  = ST_PARSE;
        end
      end
      ST_PARSE: begin
        if (beat) begin
          cap_en  = 1'b1;
          setup_d = 1'b0;
          if (te.te_in_sop) begin
            // New frame aborts the current one; a one-word new frame is also lost.
            drop_inc = te.te_in_eop ? 2'd2 : 2'd1;
            state_d  = te.te_in_eop ? ST_IDLE : ST_PARSE;
            drop_d   = 1'b0;
          end else if (hdr_last) begin
            state_d = te.te_in_eop ? ST_SETUP : ST_DRAIN;
          end else if (te.te_in_eop) begin
            drop_inc = 2'd1;
            state_d  = ST_IDLE;
          end else if (hdr_bad) begin
            drop_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (beat) begin
          setup_d = 1'b0;
          if (te.te_in_sop) begin
            cap_en   = 1'b1;
            drop_inc = te.te_in_eop ? 2'd2 : 2'd1;
            state_d  = te.te_in_eop ? ST_IDLE : ST_PARSE;
            drop_d   = 1'b0;
          end else if (te.te_in_eop) begin
            if (drop_q) begin
              drop_inc = 2'd1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_SETUP;
            end
          end
        end
      end
      ST_SETUP: begin
        if (setup_q) begin
          state_d = ST_REQ;
          tmo_d   = '0;
        end else begin
          setup_d = 1'b1;
        end
      end
      ST_REQ: begin
        rq = RQ_LOOKUP;
        if (te.te_rs_done) begin
          id_d    = te.te_rs_id;
          err_d   = te.te_rs_error;
          state_d = ST_RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
          id_d    = 8'h00;
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (te.te_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating drop counter increment.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(drop_inc);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  // State, timers, latched response and drop counter.
  always_ff @(posedge te_clk) begin
    if (!te_rst_n) begin
      state_q    <= ST_IDLE;
      drop_q     <= 1'b0;
      setup_q    <= 1'b0;
      tmo_q      <= '0;
      id_q       <= 8'h00;
      err_q      <= 8'h00;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      setup_q    <= setup_d;
      tmo_q      <= tmo_d;
      id_q       <= id_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign te.te_in_ready  = in_ready;
  assign te.te_rq        = rq;
  assign te.te_mac_src   = tuple.mac_src;
  assign te.te_mac_dst   = tuple.mac_dst;
  assign te.te_ip_src    = tuple.ip_src;
  assign te.te_ip_dst    = tuple.ip_dst;
  assign te.te_port_src  = tuple.port_src;
  assign te.te_port_dst  = tuple.port_dst;
  assign te.te_out_valid = out_valid;
  assign te.te_out_id    = id_q;
  assign te.te_out_error = err_q;
  assign te.te_drop_cnt  = drop_cnt_q;
  assign te.te_dbg_state = state_q;

endmodule
